// File: rtl/fifo_stream_ctrl.sv
// Stream sequencer for a 16-in/24-out watermark FIFO: primes to high watermark, pops one
// sample per rate tick and refills in bursts with low/high hysteresis, tracking fill in bits.
module fifo_stream_ctrl #(
  parameter int WRITE_W     = 16,
  parameter int READ_W      = 24,
  parameter int BUF_BITS    = 512,
  parameter int TICK_DIV    = 2979,
  parameter int BURST_WORDS = 32
) (
  input  logic               clk143,
  input  logic               rst_n,
  input  logic               enable,
  output logic               src_req,
  input  logic               src_valid,
  input  logic [WRITE_W-1:0] src_data,
  output logic               src_ready,
  output logic               fifo_we,
  output logic [WRITE_W-1:0] fifo_din,
  output logic               fifo_pop,
  input  logic [READ_W-1:0]  fifo_dout,
  input  logic               fifo_hw,
  input  logic               fifo_lw,
  output logic               snk_valid,
  output logic [READ_W-1:0]  snk_data,
  output logic               underrun,
  output logic [15:0]        underrun_cnt,
  output logic [1:0]         state
);

  localparam int LVL_W   = $clog2(BUF_BITS) + 1;
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BURST_W = $clog2(BURST_WORDS) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_REFILL = 2'd3;

  localparam logic [LVL_W-1:0]   WR_INC     = LVL_W'(WRITE_W);
  localparam logic [LVL_W-1:0]   RD_DEC     = LVL_W'(READ_W);
  localparam logic [LVL_W-1:0]   WR_LIMIT   = LVL_W'(BUF_BITS - WRITE_W);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_WORDS - 1);

  logic [1:0]         state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               src_req_q, src_req_d;
  logic               snk_valid_q, snk_valid_d;
  logic [READ_W-1:0]  snk_data_q, snk_data_d;
  logic               underrun_q, underrun_d;
  logic [15:0]        underrun_cnt_q, underrun_cnt_d;

  logic in_stream_s;
  logic stay_stream_s;
  logic tick_s;
  logic pop_s;
  logic ready_s;
  logic accept_s;
  logic burst_done_s;

  // Handshake, tick and pop decode from the current registered state.
  always_comb begin
    in_stream_s  = (state_q == S_RUN) || (state_q == S_REFILL);
    tick_s       = in_stream_s && (tick_cnt_q == TICK_LAST);
    pop_s        = tick_s && (level_q >= RD_DEC);
    ready_s      = src_req_q && (level_q <= WR_LIMIT);
    accept_s     = src_valid && ready_s;
    burst_done_s = accept_s && (burst_cnt_q == BURST_LAST);
  end

  // Sequencer next state; a low enable wins over every other transition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_PRIME;
        S_PRIME:  state_d = fifo_hw ? S_RUN : S_PRIME;
        S_RUN:    state_d = fifo_lw ? S_REFILL : S_RUN;
        S_REFILL: state_d = fifo_hw ? S_RUN : S_REFILL;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Burst request, fill level, rate tick and sample/underrun bookkeeping.
  always_comb begin
    stay_stream_s = in_stream_s && ((state_d == S_RUN) || (state_d == S_REFILL));
    src_req_d     = ((state_d == S_PRIME) || (state_d == S_REFILL)) && !burst_done_s;

    if (!src_req_d) begin
      burst_cnt_d = BURST_W'(0);
    end else if (accept_s) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end else begin
      burst_cnt_d = burst_cnt_q;
    end

    level_d = level_q + (accept_s ? WR_INC : LVL_W'(0)) - (pop_s ? RD_DEC : LVL_W'(0));

    if (!stay_stream_s) begin
      tick_cnt_d = TICK_W'(0);
    end else if (tick_s) begin
      tick_cnt_d = TICK_W'(0);
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    snk_valid_d    = tick_s;
    snk_data_d     = pop_s ? fifo_dout : snk_data_q;
    underrun_d     = underrun_q || (tick_s && !pop_s);
    underrun_cnt_d = underrun_cnt_q;
    if (tick_s && !pop_s && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end else begin
      underrun_cnt_d = underrun_cnt_q;
    end
  end

  // State registers; reset abandons any burst in flight without touching the FIFO.
  always_ff @(posedge clk143 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      level_q        <= LVL_W'(0);
      tick_cnt_q     <= TICK_W'(0);
      burst_cnt_q    <= BURST_W'(0);
      src_req_q      <= 1'b0;
      snk_valid_q    <= 1'b0;
      snk_data_q     <= {READ_W{1'b0}};
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      tick_cnt_q     <= tick_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      src_req_q      <= src_req_d;
      snk_valid_q    <= snk_valid_d;
      snk_data_q     <= snk_data_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign src_req      = src_req_q;
  assign src_ready    = ready_s;
  assign fifo_we      = accept_s;
  assign fifo_din     = src_data;
  assign fifo_pop     = pop_s;
  assign snk_valid    = snk_valid_q;
  assign snk_data     = snk_data_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Directed bench for fifo_stream_ctrl: a bit-level fill/tick model checks every cycle on the
// falling edge, while the stimulus sequence pins hand-computed values at phase boundaries.
module tb_fifo_stream_ctrl;

  localparam int WW = 16;
  localparam int RW = 24;
  localparam int BUF = 512;
  localparam int TDIV = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          src_valid = 1'b0;
  logic [WW-1:0] src_data = 16'h1000;
  logic [RW-1:0] fifo_dout = 24'd1;
  logic          fifo_hw = 1'b0;
  logic          fifo_lw = 1'b0;
  logic          src_req, src_ready, fifo_we, fifo_pop, snk_valid, underrun;
  logic [WW-1:0] fifo_din;
  logic [RW-1:0] snk_data;
  logic [15:0]   underrun_cnt;
  logic [1:0]    state;

  int n_vec = 0;
  int n_err = 0;
  int acc_total = 0;
  int pop_total = 0;
  int acc_mark;

  fifo_stream_ctrl #(
    .WRITE_W(WW), .READ_W(RW), .BUF_BITS(BUF), .TICK_DIV(TDIV), .BURST_WORDS(BW)
  ) dut (
    .clk143(clk), .rst_n(rst_n), .enable(enable),
    .src_req(src_req), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout),
    .fifo_hw(fifo_hw), .fifo_lw(fifo_lw),
    .snk_valid(snk_valid), .snk_data(snk_data), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: stream phase counts cycles since RUN entry; level is the true fill in bits.
  int   m_state, m_level, m_phase, m_burst, m_urc;
  logic m_req, m_sv, m_ur;
  logic [RW-1:0] m_sd;
  logic e_ready, e_we, e_tick, e_pop, streaming;
  int   nxt;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_level = 0; m_phase = 0; m_burst = 0; m_urc = 0;
      m_req = 1'b0; m_sv = 1'b0; m_ur = 1'b0; m_sd = '0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_src_req", 32'(src_req), 32'd0);
      chk("rst_snk_valid", 32'(snk_valid), 32'd0);
      chk("rst_snk_data", 32'(snk_data), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
      chk("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    end else begin
      streaming = (m_state == 2) || (m_state == 3);
      e_ready   = m_req && (m_level + WW <= BUF);
      e_we      = src_valid && e_ready;
      e_tick    = streaming && ((m_phase % TDIV) == TDIV - 1);
      e_pop     = e_tick && (m_level >= RW);
      chk("state", 32'(state), 32'(m_state));
      chk("src_req", 32'(src_req), 32'(m_req));
      chk("src_ready", 32'(src_ready), 32'(e_ready));
      chk("fifo_we", 32'(fifo_we), 32'(e_we));
      chk("fifo_din", 32'(fifo_din), 32'(src_data));
      chk("fifo_pop", 32'(fifo_pop), 32'(e_pop));
      chk("snk_valid", 32'(snk_valid), 32'(m_sv));
      chk("snk_data", 32'(snk_data), 32'(m_sd));
      chk("underrun", 32'(underrun), 32'(m_ur));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_urc));
      // Advance the model to what the next rising edge must produce.
      if (!enable) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (m_state == 1) nxt = fifo_hw ? 2 : 1;
      else if (m_state == 2) nxt = fifo_lw ? 3 : 2;
      else nxt = fifo_hw ? 2 : 3;
      m_level = m_level + (e_we ? WW : 0) - (e_pop ? RW : 0);
      m_sv = e_tick;
      if (e_pop) m_sd = fifo_dout;
      if (e_tick && !e_pop) begin
        m_ur = 1'b1;
        if (m_urc < 65535) m_urc++;
      end
      m_phase = (streaming && (nxt == 2 || nxt == 3)) ? m_phase + 1 : 0;
      if (e_we) m_burst++;
      if (m_burst == BW || !(nxt == 1 || nxt == 3)) begin
        m_req = 1'b0;
        m_burst = 0;
      end else begin
        m_req = 1'b1;
      end
      m_state = nxt;
    end
  end

  // One clock: note accept/pop, then advance the source word and FIFO head after the edge.
  task automatic step();
    logic we_seen, pop_seen;
    @(negedge clk);
    we_seen = fifo_we;
    pop_seen = fifo_pop;
    @(posedge clk);
    #1;
    if (we_seen) begin
      src_data = src_data + 16'd1;
      acc_total++;
    end
    if (pop_seen) begin
      fifo_dout = fifo_dout + 24'd1;
      pop_total++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
    chk("idle_state", 32'(state), 32'd0);

    // Prime with an always-valid source: 4 accepts then one idle cycle, repeating.
    enable = 1'b1;
    src_valid = 1'b1;
    step();
    chk("prime_entry", 32'(state), 32'd1);
    steps(20);
    chk("prime_accepts", 32'(acc_total), 32'd16);
    chk("prime_no_pop", 32'(pop_total), 32'd0);
    fifo_hw = 1'b1;
    step();
    fifo_hw = 1'b0;
    chk("run_entry", 32'(state), 32'd2);
    chk("model_lvl_272", 32'(m_level), 32'd272);

    // Run: samples 1..5 at 8-cycle spacing.
    steps(7);
    chk("no_sample_yet", 32'(snk_valid), 32'd0);
    step();
    chk("first_sample_v", 32'(snk_valid), 32'd1);
    chk("first_sample_d", 32'(snk_data), 32'd1);
    steps(32);
    chk("fifth_sample_d", 32'(snk_data), 32'd5);
    chk("fifth_sample_v", 32'(snk_valid), 32'd1);
    chk("model_lvl_152", 32'(m_level), 32'd152);

    // Refill with a stalled source: drain to 8 bits, then two underrun ticks.
    src_valid = 1'b0;
    fifo_lw = 1'b1;
    step();
    fifo_lw = 1'b0;
    chk("refill_entry", 32'(state), 32'd3);
    steps(63);
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_cnt_2", 32'(underrun_cnt), 32'd2);
    chk("ur_data_held", 32'(snk_data), 32'd11);

    // Write lands on the same cycle as a pop at level 24: level becomes 16.
    steps(6);
    src_valid = 1'b1;
    steps(2);
    src_valid = 1'b0;
    chk("wr_pop_data", 32'(snk_data), 32'd12);
    chk("model_lvl_16", 32'(m_level), 32'd16);
    steps(8);
    chk("ur_cnt_3", 32'(underrun_cnt), 32'd3);
    chk("ur_data_held2", 32'(snk_data), 32'd12);

    // Drop enable in REFILL, then re-prime from the preserved level until full.
    enable = 1'b0;
    step();
    chk("disable_idle", 32'(state), 32'd0);
    chk("disable_req", 32'(src_req), 32'd0);
    steps(2);
    enable = 1'b1;
    src_valid = 1'b1;
    acc_mark = acc_total;
    step();
    chk("reprime", 32'(state), 32'd1);
    steps(45);
    chk("fill_accepts", 32'(acc_total - acc_mark), 32'd31);
    chk("full_not_ready", 32'(src_ready), 32'd0);
    chk("full_req_held", 32'(src_req), 32'd1);

    // Go to REFILL and hit reset between edges while a burst is requested.
    fifo_hw = 1'b1;
    step();
    fifo_hw = 1'b0;
    fifo_lw = 1'b1;
    step();
    fifo_lw = 1'b0;
    chk("pre_rst_state", 32'(state), 32'd3);
    chk("pre_rst_req", 32'(src_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_req", 32'(src_req), 32'd0);
    chk("async_ur_cnt", 32'(underrun_cnt), 32'd0);
    chk("async_ur", 32'(underrun), 32'd0);
    chk("async_snk_data", 32'(snk_data), 32'd0);
    steps(2);
    rst_n = 1'b1;
    enable = 1'b0;
    steps(3);
    chk("final_idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
